tc_timer: RTL and testbench
===========================

TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes on posedge.
REQ-002 reset  input  1  synchronous, active-high; clock clk.
REQ-003 addr  input  2  word select, taken from bus address bits [3:2]; 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 we  input  1  word write strobe; only full-word writes reach this block.
REQ-005 wdata  input  32  write data.
REQ-006 rdata  output  32  combinational read data for addr.
REQ-007 irq  output  1  interrupt request to the CPU (feeds its tIBQ0/tIBQ1 inputs).

Function
REQ-008 CTRL[0]=EN, CTRL[2:1]=MODE (0 one-shot, 1 auto-reload, 2/3 treated as 0), CTRL[3]=IM; CTRL[31:4] SHALL read 0.
REQ-009 rdata SHALL be {28'b0,CTRL[3:0]}, PRESET or COUNT for addr 0/1/2, and 0 for addr 3.
REQ-010 A write with we=1 SHALL update CTRL[3:0] or PRESET on that edge; writes to COUNT or reserved SHALL be ignored.
REQ-011 FSM states SHALL be IDLE, LOAD, CNT and INT.
REQ-012 IDLE: EN=1 -> LOAD; otherwise stay; COUNT holds.
REQ-013 LOAD: COUNT<=PRESET, state -> CNT.
REQ-014 CNT with EN=0: state -> IDLE, COUNT holds (pause).
REQ-015 CNT with EN=1 and COUNT>1: COUNT<=COUNT-1, stay.
REQ-016 CNT with EN=1 and COUNT<=1: COUNT<=0, set irq_flag, state -> INT.
REQ-017 INT with MODE=0: EN<=0, state -> IDLE; irq_flag holds until the next CTRL write.
REQ-018 INT with MODE=1: irq_flag<=0 (one-cycle pulse), state -> LOAD.
REQ-019 irq SHALL be irq_flag AND IM, combinational from registered state.
REQ-020 Latency: a write setting EN at edge E0 with PRESET=N>=1 SHALL raise irq after edge E0+N+2; PRESET=0 behaves as PRESET=1.
REQ-021 If a CTRL write and an FSM clear of EN (REQ-017) occur on the same edge, the bus write SHALL win.
REQ-022 Any CTRL write SHALL clear irq_flag on that edge; if the FSM sets irq_flag on the same edge, the set SHALL win.
REQ-023 A PRESET write during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-024 COUNT arithmetic is 32-bit unsigned; it SHALL never wrap below 0.

Reset
REQ-025 On reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0, rdata=0.
REQ-026 Reset mid-count SHALL abort the count with no irq pulse; reset SHALL override a simultaneous we.

Configuration
REQ-027 Macro TC_AUTORELOAD_EN defined: MODE=1 SHALL behave per REQ-018.
REQ-028 Macro TC_AUTORELOAD_EN undefined: MODE SHALL be forced to 0, CTRL[2:1] SHALL read 0, and every INT SHALL follow REQ-017.

Structure
REQ-029 Package tc_pkg SHALL hold the state encoding, the register offsets (CTRL=0, PRESET=1, COUNT=2) and the CTRL bit positions.
REQ-030 Implemented as a single module with no sub-module; two instances sit at 0x7F00 and 0x7F10 behind the bridge.

Verification
REQ-031 Reset, then read all three addresses -> rdata=0 each; irq=0.
REQ-032 PRESET=5, CTRL=0x9 (EN, IM, mode 0) -> irq rises 7 edges after the CTRL write; COUNT=0; CTRL reads 0x8; irq stays high until a CTRL write of 0x8, then drops.
REQ-033 With TC_AUTORELOAD_EN defined: PRESET=3, CTRL=0xB -> one-cycle irq pulses repeat every 5 cycles; with the macro undefined -> a single held irq, and CTRL reads 0x9.
REQ-034 PRESET=10, CTRL=0x1; after 4 edges in CNT write CTRL=0 -> COUNT frozen at 6; write CTRL=0x1 -> LOAD reloads 10.
REQ-035 PRESET=2, CTRL=0x1 (IM=0) -> COUNT reaches 0 and EN clears while irq stays 0; a subsequent CTRL=0x8 write raises no irq.
REQ-036 Write COUNT=0x1234 -> ignored; assert reset during CNT -> next cycle all registers are 0 and irq never pulses.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the tc_timer block: FSM state encoding,
// register word offsets (bus address bits [3:2]) and CTRL bit positions.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/tc_timer.sv
// Purpose: down-counting timer with CTRL/PRESET/COUNT registers and a maskable irq; auto-reload via TC_AUTORELOAD_EN.
// Latency: EN written at edge E0 with PRESET=N (N>=1, 0 acts as 1) raises irq after edge E0+N+2; rdata is combinational.
// Backpressure: none; every full-word write is accepted on its edge, COUNT/reserved writes are dropped.
module tc_timer
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        en;
  logic        mode_reload;
  logic        fsm_set_flag;
  logic [3:0]  ctrl_wr;
  logic        unused_wdata;

  assign en = ctrl_q[CTRL_EN];
  assign unused_wdata = ^wdata[31:4];

`ifdef TC_AUTORELOAD_EN
  assign mode_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign ctrl_wr     = wdata[3:0];
`else
  // Without auto-reload support the MODE field is hardwired to one-shot.
  assign mode_reload = 1'b0;
  assign ctrl_wr     = {wdata[CTRL_IM], MODE_ONESHOT, wdata[CTRL_EN]};
`endif

  // Next-state logic: FSM first, then bus writes so a CTRL write overrides the FSM's EN clear.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    irq_flag_d   = irq_flag_q;
    fsm_set_flag = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET=0 lands here too, so the count never wraps below zero.
          count_d      = 32'd0;
          irq_flag_d   = 1'b1;
          fsm_set_flag = 1'b1;
          state_d      = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_reload) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (we && addr == ADDR_CTRL) begin
      ctrl_d = ctrl_wr;
      // A CTRL write acknowledges the interrupt unless a new one fires on this very edge.
      if (!fsm_set_flag) irq_flag_d = 1'b0;
    end
    if (we && addr == ADDR_PRESET) begin
      preset_d = wdata;
    end
  end

  // State registers with synchronous reset; reset beats any write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux; the reserved word reads as zero.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl_q};
      ADDR_PRESET: rdata = preset_q;
      ADDR_COUNT:  rdata = count_q;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: register access, one-shot/auto-reload timing,
// pause/resume, masked irq, write/FSM same-edge priority and reset abort.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  logic [31:0] v;
  int          first;
  int          high;
  int          k;
  logic        irq_seen;

  initial begin
    // Reset with a simultaneous CTRL write that must be ignored.
    reset = 1'b1;
    we    = 1'b1;
    addr  = 2'd0;
    wdata = 32'hF;
    tick();
    tick();
    reset = 1'b0;
    we    = 1'b0;
    wdata = 32'd0;
    rd(2'd0, v); chk("rst_ctrl", v, 32'd0);
    rd(2'd1, v); chk("rst_preset", v, 32'd0);
    rd(2'd2, v); chk("rst_count", v, 32'd0);
    rd(2'd3, v); chk("rst_reserved", v, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot: PRESET=5, CTRL=0x9 -> irq after 7 edges, held until CTRL write.
    wr(2'd1, 32'd5);
    rd(2'd1, v); chk("preset_wr", v, 32'd5);
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, v); chk("os_load_count", v, 32'd5);
    first = 0;
    k = 2;
    while (first == 0 && k < 20) begin
      tick();
      k++;
      if (irq) first = k;
    end
    chk("os_irq_latency", first, 32'd7);
    rd(2'd2, v); chk("os_count_zero", v, 32'd0);
    tick();
    rd(2'd0, v); chk("os_ctrl_en_clr", v, 32'h8);
    tick(); tick(); tick();
    chk("os_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8);
    chk("os_irq_ack", {31'd0, irq}, 32'd0);

    // Auto-reload request: PRESET=3, CTRL=0xB.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd(2'd0, v);
`ifdef TC_AUTORELOAD_EN
    chk("ar_ctrl_rd", v, 32'hB);
`else
    chk("ar_ctrl_rd", v, 32'h9);
`endif
    first = 0;
    high  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (irq) begin
        high++;
        if (first == 0) first = i;
      end
    end
    chk("ar_first_irq", first, 32'd5);
`ifdef TC_AUTORELOAD_EN
    chk("ar_pulse_cycles", high, 32'd4);
    rd(2'd0, v); chk("ar_ctrl_kept", v, 32'hB);
`else
    chk("ar_held_cycles", high, 32'd16);
    rd(2'd0, v); chk("ar_ctrl_oneshot", v, 32'h8);
`endif
    wr(2'd0, 32'h0);
    tick(); tick(); tick(); tick();

    // Pause/resume: PRESET=10, pause at COUNT=6, resume reloads 10.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(); tick(); tick(); tick(); tick();
    rd(2'd2, v); chk("pr_count7", v, 32'd7);
    wr(2'd0, 32'h0);
    tick(); tick(); tick();
    rd(2'd2, v); chk("pr_frozen6", v, 32'd6);
    wr(2'd0, 32'h1);
    tick();
    tick();
    rd(2'd2, v); chk("pr_reload10", v, 32'd10);
    // PRESET write while counting must not disturb COUNT.
    wr(2'd1, 32'd20);
    rd(2'd2, v); chk("pr_preset_mid_cnt", v, 32'd9);
    rd(2'd1, v); chk("pr_preset_new", v, 32'd20);
    tick(); tick();
    rd(2'd2, v); chk("pr_count7b", v, 32'd7);
    wr(2'd0, 32'h0);
    tick(); tick();

    // Masked: PRESET=2, CTRL=0x1 -> expires, EN clears, irq stays low.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    irq_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq) irq_seen = 1'b1;
    end
    chk("im0_no_irq", {31'd0, irq_seen}, 32'd0);
    rd(2'd2, v); chk("im0_count0", v, 32'd0);
    rd(2'd0, v); chk("im0_en_clr", v, 32'h0);
    wr(2'd0, 32'h8);
    chk("im0_unmask_no_irq", {31'd0, irq}, 32'd0);

    // Same-edge priority, with PRESET=0 behaving as 1.
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    wr(2'd0, 32'h9);
    chk("pri_set_wins", {31'd0, irq}, 32'd1);
    rd(2'd2, v); chk("pri_no_wrap", v, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd0, v); chk("pri_bus_en_wins", v, 32'h9);
    chk("pri_ack", {31'd0, irq}, 32'd0);
    tick(); tick(); tick();
    chk("pri_rerun_irq", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h0);
    tick();

    // COUNT is read-only; reset mid-count aborts with no irq.
    wr(2'd2, 32'h1234);
    rd(2'd2, v); chk("count_ro", v, 32'd0);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    rd(2'd2, v); chk("rst_mid_count", v, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(2'd0, v); chk("rst2_ctrl", v, 32'd0);
    rd(2'd1, v); chk("rst2_preset", v, 32'd0);
    rd(2'd2, v); chk("rst2_count", v, 32'd0);
    irq_seen = irq;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq) irq_seen = 1'b1;
    end
    chk("rst2_no_irq", {31'd0, irq_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
